fir_filter_top: RTL and testbench



---
 rtl/fir_filter_top.sv | 181 ++++++++++++++++++
 tb/tb_fir_filter_top.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_top.sv
// -----------------------------------------------------------------------------
// fir_filter_top
//
// Streaming fixed-coefficient FIR filter. Signed Q1.15 samples in, filtered
// signed Q1.15 samples out, one sample per clock at full throughput.
//
// Datapath:
//   delay line (NTAPS x 16b)  ->  stage 1: NTAPS parallel 16x16 products
//                             ->  stage 2: sum, round half up, >>> 15,
//                                          saturate or wrap to 16 bits
//
// Parameters:
//   NTAPS  number of taps (>= 2), default 8
//   COEFS  packed NTAPS x 16-bit signed Q1.15 coefficients, h[0] in [15:0].
//          The default (8 x 16'h1000) is a 1/8 moving average.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   i_data   in   16-bit signed input sample
//   i_valid  in   i_data is valid
//   o_ready  out  block accepts an input sample this cycle
//   o_data   out  16-bit signed filtered sample
//   o_valid  out  o_data is valid
//   i_ready  in   downstream accepts o_data this cycle
//
// Build option:
//   FIR_SAT_EN  when defined, the rounded result saturates to 16'h7FFF /
//               16'h8000 on overflow. When undefined, the result is simply
//               truncated to its low 16 bits (two's-complement wrap) and no
//               saturation logic is built.
// -----------------------------------------------------------------------------
module fir_filter_top #(
    parameter int                  NTAPS = 8,
    parameter logic [NTAPS*16-1:0] COEFS = {8{16'h1000}}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [15:0] o_data,
    output logic        o_valid,
    input  logic        i_ready
);

    // Accumulator wide enough that the sum of NTAPS full-scale 32-bit
    // products can never overflow.
    localparam int AW = 32 + $clog2(NTAPS);
    // Width of the accumulator after dropping the 15 fractional bits.
    localparam int SW = AW - 15;

    // Round-half-up constant: 2^14 in accumulator width.
    localparam logic signed [AW-1:0] RND = {{(AW-15){1'b0}}, 1'b1, 14'b0};

    // -------------------------------------------------------------------------
    // Handshake semantics (both sides):
    //   A transfer happens at a rising clk edge when valid && ready are both
    //   high. A source holding valid high keeps its data stable until the
    //   transfer. Here o_ready is a pure function of the output register
    //   state and i_ready (never of i_valid): the whole pipeline moves
    //   ("advance") whenever the output register is empty or is being
    //   drained this cycle; otherwise every stage holds.
    // -------------------------------------------------------------------------
    logic advance;
    logic accept;

    assign advance = !o_valid || i_ready;
    assign o_ready = advance;
    assign accept  = i_valid && advance;

    // -------------------------------------------------------------------------
    // Coefficients, unpacked for readability. Constant: no run-time reload.
    // -------------------------------------------------------------------------
    logic signed [15:0] coef [NTAPS];

    for (genvar k = 0; k < NTAPS; k++) begin : g_coef
        assign coef[k] = COEFS[16*k +: 16];
    end

    // -------------------------------------------------------------------------
    // Delay line. x_win is the window as it will look after this edge:
    // shifted by one with the new sample in tap 0 on accept, unchanged
    // otherwise. Stage 1 multiplies this post-shift window so a sample's
    // result leaves the block exactly two edges after it was accepted.
    // -------------------------------------------------------------------------
    logic signed [15:0] x_q   [NTAPS];
    logic signed [15:0] x_win [NTAPS];

    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            x_win[k] = x_q[k];
        end
        if (accept) begin
            x_win[0] = i_data;
            for (int k = 1; k < NTAPS; k++) begin
                x_win[k] = x_q[k-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: registered products.
    // -------------------------------------------------------------------------
    logic signed [31:0] p_q [NTAPS];
    logic               s1_valid;

    // -------------------------------------------------------------------------
    // Stage 2 combinational part: sum, round, scale, limit.
    // -------------------------------------------------------------------------
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] rounded;
    logic signed [SW-1:0] scaled;
    logic        [15:0]   result;

    always_comb begin
        acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            acc = acc + AW'(p_q[k]);
        end
    end

    assign rounded = acc + RND;
    // Arithmetic shift right by 15: keep the integer part of the rounded sum.
    assign scaled  = rounded[AW-1:15];

`ifdef FIR_SAT_EN
    localparam logic signed [SW-1:0] MAX_OUT = SW'(32767);
    localparam logic signed [SW-1:0] MIN_OUT = SW'(-32768);

    always_comb begin
        if (scaled > MAX_OUT) begin
            result = 16'h7FFF;
        end else if (scaled < MIN_OUT) begin
            result = 16'h8000;
        end else begin
            result = scaled[15:0];
        end
    end

    // The fractional bits are consumed by rounding only.
    logic unused_frac;
    assign unused_frac = ^rounded[14:0];
`else
    // Wrap: keep the low 16 bits of the scaled result.
    assign result = scaled[15:0];

    // Fractional bits and the overflow headroom are dropped on purpose.
    logic unused_frac;
    assign unused_frac = ^{rounded[14:0], scaled[SW-1:16]};
`endif

    // -------------------------------------------------------------------------
    // Sequential state: delay line, stage 1, stage 2 output register.
    // Everything moves together on advance and holds on a stall.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= '0;
                p_q[k] <= '0;
            end
            s1_valid <= 1'b0;
            o_valid  <= 1'b0;
            o_data   <= '0;
        end else if (advance) begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= x_win[k];
                p_q[k] <= 32'(coef[k]) * 32'(x_win[k]);
            end
            s1_valid <= accept;
            o_valid  <= s1_valid;
            // o_data only changes when a new result arrives, so it keeps
            // the last delivered sample across idle gaps.
            if (s1_valid) begin
                o_data <= result;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter_top.sv
// -----------------------------------------------------------------------------
// tb_fir_filter_top
//
// Scoreboard bench for fir_filter_top. Two instances share clock and reset:
// dut uses the default 1/8 moving-average coefficients, dut_ov uses
// 8 x 16'h7FFF so the output range is exceeded. A reference model computes
// each expected output from the accepted-sample history with plain integer
// arithmetic and pushes it into an expected queue; monitor processes pop
// and compare on every output transfer.
// -----------------------------------------------------------------------------
module tb_fir_filter_top;

    localparam int NT = 8;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT signals
    logic [15:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] o_data;
    logic        o_valid;
    logic        i_ready;

    logic [15:0] ov_data;
    logic        ov_valid;
    logic        ov_oready;
    logic [15:0] ov_odata;
    logic        ov_ovalid;
    logic        ov_iready;

    fir_filter_top #(.NTAPS(NT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    fir_filter_top #(.NTAPS(NT), .COEFS({8{16'h7FFF}})) dut_ov (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (ov_data),
        .i_valid (ov_valid),
        .o_ready (ov_oready),
        .o_data  (ov_odata),
        .o_valid (ov_ovalid),
        .i_ready (ov_iready)
    );

    // ---------------------------------------------------------------- bookkeeping
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    logic signed [15:0] coef_main [NT];
    logic signed [15:0] coef_ov   [NT];
    logic signed [15:0] hist  [$];   // hist[k] = k-th most recent accepted sample
    logic signed [15:0] hist2 [$];
    logic [15:0]        exp_q  [$];
    logic [15:0]        exp_q2 [$];

    function automatic logic [15:0] round_out(input longint s);
        longint      r;
        logic [63:0] rb;
        r = (s + 64'sd16384) >>> 15;
`ifdef FIR_SAT_EN
        if (r > 32767)  return 16'h7FFF;
        if (r < -32768) return 16'h8000;
`endif
        rb = r;
        return rb[15:0];
    endfunction

    task automatic reset_hist();
        hist.delete();
        hist2.delete();
        for (int k = 0; k < NT; k++) begin
            hist.push_back('0);
            hist2.push_back('0);
        end
    endtask

    task automatic push_main(input logic [15:0] d);
        longint s = 0;
        hist.push_front(d);
        void'(hist.pop_back());
        for (int k = 0; k < NT; k++) s += longint'(coef_main[k]) * longint'(hist[k]);
        exp_q.push_back(round_out(s));
    endtask

    task automatic push_ov(input logic [15:0] d);
        longint s = 0;
        hist2.push_front(d);
        void'(hist2.pop_back());
        for (int k = 0; k < NT; k++) s += longint'(coef_ov[k]) * longint'(hist2[k]);
        exp_q2.push_back(round_out(s));
    endtask

    // ---------------------------------------------------------------- drivers
    int stall_cnt = 0;   // cycles of i_ready = 0 still to apply

    task automatic drive(input logic v, input logic [15:0] d, output logic acc);
        @(negedge clk);
        i_valid = v;
        i_data  = d;
        i_ready = (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
        #1;
        acc = v && o_ready && rst_n;
        if (acc) push_main(d);
    endtask

    task automatic send(input logic [15:0] d);
        logic acc;
        int   tries = 0;
        do begin
            drive(1'b1, d, acc);
            tries++;
        end while (!acc && tries < 20);
        check("send_accept", acc, 1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, acc);
    endtask

    task automatic ov_send(input logic v, input logic [15:0] d);
        @(negedge clk);
        ov_valid = v;
        ov_data  = d;
        #1;
        if (v && ov_oready && rst_n) push_ov(d);
    endtask

    // Asserts reset at a negedge with a sample presented (it must be
    // discarded), checks the outputs clear at once, then releases.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n   = 1'b0;
        i_valid = 1'b1;
        i_data  = 16'h7FFF;
        #1;
        check("rst_o_valid", o_valid, 0);
        check("rst_o_data", o_data, 16'h0000);
        check("rst_o_ready", o_ready, 1);
        exp_q.delete();
        exp_q2.delete();
        reset_hist();
        repeat (cycles) @(negedge clk);
        rst_n   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
    endtask

    // ---------------------------------------------------------------- monitors
    logic        held = 1'b0;
    logic [15:0] held_data;

    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", o_valid, 1);
                check("hold_data", o_data, held_data);
            end
            if (o_valid && !i_ready) begin
                check("stall_o_ready", o_ready, 0);
                held      = 1'b1;
                held_data = o_data;
            end else begin
                held = 1'b0;
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", o_data);
                end else begin
                    check("out_data", o_data, exp_q.pop_front());
                end
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (rst_n && ov_ovalid && ov_iready) begin
            if (exp_q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ov_output: got %h expected none", ov_odata);
            end else begin
                check("ov_out_data", ov_odata, exp_q2.pop_front());
            end
        end
    end

    // ---------------------------------------------------------------- test sequence
    initial begin
        logic acc;
        i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
        ov_valid = 1'b0; ov_data = '0; ov_iready = 1'b1;
        for (int k = 0; k < NT; k++) begin
            coef_main[k] = 16'sh1000;
            coef_ov[k]   = 16'sh7FFF;
        end
        reset_hist();

        // Reset, then 10 idle cycles with no output activity.
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("idle_o_valid", o_valid, 0);
            check("idle_o_data", o_data, 16'h0000);
            check("idle_o_ready", o_ready, 1);
        end

        // Positive and negative impulses.
        send(16'h7FFF);
        for (int i = 0; i < 15; i++) send(16'h0000);
        idle(3);
        send(16'h8000);
        for (int i = 0; i < 15; i++) send(16'h0000);
        idle(3);

        // Step with explicit latency check: result visible after edge N+1.
        send(16'h4000);
        drive(1'b0, 16'h0000, acc);
        check("lat_not_yet", o_valid, 0);
        drive(1'b0, 16'h0000, acc);
        check("lat_valid", o_valid, 1);
        check("lat_data", o_data, 16'h0800);
        for (int i = 0; i < 12; i++) send(16'h4000);
        idle(3);

        // Step with a 3-cycle downstream stall mid-stream.
        do_reset(2);
        for (int i = 0; i < 4; i++) send(16'h4000);
        stall_cnt = 3;
        for (int i = 0; i < 10; i++) send(16'h4000);
        idle(3);

        // Reset mid-stream while o_valid = 1, then a clean impulse.
        for (int i = 0; i < 3; i++) send(16'h4000);
        do_reset(2);
        send(16'h7FFF);
        for (int i = 0; i < 15; i++) send(16'h0000);
        idle(3);

        // Random traffic with random valid gaps and random stalls.
        for (int i = 0; i < 300; i++) begin
            if (stall_cnt == 0 && $urandom_range(0, 9) == 0) stall_cnt = $urandom_range(1, 3);
            drive($urandom_range(0, 3) != 0, 16'($urandom), acc);
        end
        idle(5);

        // Overflow instance: continuous full scale, then random.
        for (int i = 0; i < 12; i++) ov_send(1'b1, 16'h7FFF);
        for (int i = 0; i < 12; i++) ov_send(1'b1, 16'h8000);
        for (int i = 0; i < 40; i++) ov_send($urandom_range(0, 3) != 0, 16'($urandom));
        ov_send(1'b0, 16'h0000);

        // Drain, bounded.
        for (int i = 0; i < 40 && (exp_q.size() != 0 || exp_q2.size() != 0); i++) idle(1);
        check("drain_main", exp_q.size(), 0);
        check("drain_ov", exp_q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
